logic_unit: RTL and testbench
=============================

Name: logic_unit

Overview:
- Parameterised N-bit bitwise logic unit: AND, OR, XOR and NOR of two operands, selected by a 2-bit control code.
- Sits in the ALU datapath beside the arithmetic unit; the ALU output mux chooses between them.
- Result and status flags are registered, giving one cycle of latency, with a simple valid qualifier.

Parameters:
- N, 4, operand and result width in bits; legal for N >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and control are valid this cycle
- A  input  N  operand A
- B  input  N  operand B
- alu_control  input  2  operation select
- result  output  N  registered logic result
- out_valid  output  1  result and flags are valid
- zero  output  1  result is all zeros
- ones  output  1  result is all ones
- parity  output  1  XOR reduction of result (odd parity)

Interface:
- One clock; reset is synchronous and active-low.

Behaviour:
- Opcode map for alu_control:
  - 2'b00 AND: A & B
  - 2'b01 OR: A | B
  - 2'b10 XOR: A ^ B
  - 2'b11 NOR: ~(A | B)
- All four codes are defined; there is no illegal opcode.
- Reset: on a rising clk edge with rst_n=0, drive result=0, out_valid=0, zero=1, ones=0, parity=0. Reset overrides in_valid in the same cycle.
- Latency is exactly 1 cycle. On a rising edge with rst_n=1:
  - out_valid <= in_valid.
  - If in_valid=1, result <= op(A, B, alu_control), and the flags are computed from that new value.
  - If in_valid=0, result and flags hold their previous values; only out_valid drops to 0.
- Flags always describe the registered result:
  - zero = (result == 0)
  - ones = (result == all ones)
  - parity = ^result
- Widths: every operation is strictly bitwise at width N. There is no carry and no sign extension. NOR inverts every one of the N bits.
- Back-to-back: a new operation may be accepted every cycle, with no stall or backpressure. Each accepted input produces exactly one out_valid pulse one cycle later.
- Reset mid-stream: an operation accepted in the cycle before reset asserts is discarded; out_valid reads 0 after the reset edge.
- X-safety: while in_valid=0, A, B and alu_control may be X without corrupting the held outputs.

Decomposition:
- Shared package alu_pkg holds:
  - enum logic_op_e: LOP_AND=2'b00, LOP_OR=2'b01, LOP_XOR=2'b10, LOP_NOR=2'b11
  - localparam LOP_W=2
- The arithmetic unit and top-level ALU mux reuse this package.
- One natural sub-module, logic_unit_core: purely combinational, N-bit op select plus the three flag reductions.
- The top module logic_unit adds the input qualification and the output register stage.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> result=0, out_valid=0, zero=1, ones=0, parity=0.
- Opcode sweep, N=4, A=4'b0010, B=4'b0001, one cycle per code 00/01/10/11 with in_valid=1:
  - 00 -> result 0, zero=1
  - 01 -> result 3
  - 10 -> result 3, parity=0
  - 11 -> result 12 (4'b1100)
  - Each result appears one cycle after its input with out_valid=1.
- Extremes: A=4'hF, B=4'hF:
  - AND -> 15, ones=1, parity=0
  - XOR -> 0, zero=1
  - NOR -> 0
- Extremes: A=0, B=0, NOR -> 15, ones=1.
- Hold: accept AND of 4'hA and 4'h6 (result 2), then hold in_valid=0 for 3 cycles with random or X operands -> result stays 2 and out_valid=0 for those cycles.
- Reset mid-stream: accept OR of 5 and 2, then assert rst_n=0 on the next edge -> out_valid=0 and result=0; value 7 never appears.
- Random regression: N=8 and N=1, 1000 random cycles with random in_valid -> a scoreboard model with 1-cycle delay matches result, all flags and out_valid every cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encoding and control width, used by the
// logic unit, the arithmetic unit and the top-level ALU mux.
package alu_pkg;

    localparam int LOP_W = 2;

    typedef enum logic [LOP_W-1:0] {
        LOP_AND = 2'b00,
        LOP_OR  = 2'b01,
        LOP_XOR = 2'b10,
        LOP_NOR = 2'b11
    } logic_op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational N-bit bitwise operation select plus zero/ones/parity reductions
// of the selected value.
module logic_unit_core
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [LOP_W-1:0] alu_control,
    output logic [N-1:0]     res,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic_op_e op;
    assign op = logic_op_e'(alu_control);

    // Each result bit depends only on the matching operand bits: no carries.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bit
            always_comb begin
                res[gi] = 1'b0;
                case (op)
                    LOP_AND: res[gi] = a[gi] & b[gi];
                    LOP_OR:  res[gi] = a[gi] | b[gi];
                    LOP_XOR: res[gi] = a[gi] ^ b[gi];
                    LOP_NOR: res[gi] = ~(a[gi] | b[gi]);
                    default: res[gi] = 1'b0;
                endcase
            end
        end
    endgenerate

    assign zero   = ~|res;
    assign ones   = &res;
    assign parity = ^res;

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit: one-cycle latency, valid qualifier, and flags
// that always describe the held result.
module logic_unit
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic [LOP_W-1:0] alu_control,
    output logic [N-1:0]     result,
    output logic             out_valid,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic [N-1:0] result_next;
    logic         zero_next;
    logic         ones_next;
    logic         parity_next;

    logic [N-1:0] result_reg;
    logic         out_valid_reg;
    logic         zero_reg;
    logic         ones_reg;
    logic         parity_reg;

    logic_unit_core #(.N(N)) u_core (
        .a           (A),
        .b           (B),
        .alu_control (alu_control),
        .res         (result_next),
        .zero        (zero_next),
        .ones        (ones_next),
        .parity      (parity_next)
    );

    // Result and flags only load on accepted inputs, so garbage operands
    // presented while in_valid is low never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            zero_reg      <= 1'b1;
            ones_reg      <= 1'b0;
            parity_reg    <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                result_reg <= result_next;
                zero_reg   <= zero_next;
                ones_reg   <= ones_next;
                parity_reg <= parity_next;
            end
        end
    end

    assign result    = result_reg;
    assign out_valid = out_valid_reg;
    assign zero      = zero_reg;
    assign ones      = ones_reg;
    assign parity    = parity_reg;

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit at N=4, N=8 and N=1 against an arithmetic
// reference model with a one-cycle delay.
module tb_logic_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv4, iv8, iv1;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic [1:0] op4, op8, op1;

    logic [3:0] r4;
    logic [7:0] r8;
    logic [0:0] r1;
    logic       ov4, ov8, ov1, z4, z8, z1, o4, o8, o1, p4, p8, p1;

    logic_unit #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv4), .A(a4), .B(b4),
        .alu_control(op4), .result(r4), .out_valid(ov4), .zero(z4), .ones(o4), .parity(p4));
    logic_unit #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(iv8), .A(a8), .B(b8),
        .alu_control(op8), .result(r8), .out_valid(ov8), .zero(z8), .ones(o8), .parity(p8));
    logic_unit #(.N(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1),
        .alu_control(op1), .result(r1), .out_valid(ov1), .zero(z1), .ones(o1), .parity(p1));

    int checks = 0;
    int errors = 0;

    // Expected registered state per instance: index 0 -> N=4, 1 -> N=8, 2 -> N=1
    logic [31:0] exp_r [3];
    logic        exp_v [3];

    function automatic logic [31:0] mask_of(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // NOR computed as "all ones minus OR" to stay independent of gate-level form
    function automatic logic [31:0] model_op(input int n, input logic [31:0] a,
                                             input logic [31:0] b, input logic [1:0] op);
        logic [31:0] m;
        m = mask_of(n);
        a = a & m;
        b = b & m;
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return m - (a | b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input string name, input int idx, input int n,
                            input logic [31:0] r, input logic v, input logic z,
                            input logic o, input logic p);
        chk({name, "_result"}, r, exp_r[idx]);
        chk({name, "_out_valid"}, 32'(v), 32'(exp_v[idx]));
        chk({name, "_zero"}, 32'(z), 32'(exp_r[idx] == 32'd0));
        chk({name, "_ones"}, 32'(o), 32'(exp_r[idx] == mask_of(n)));
        chk({name, "_parity"}, 32'(p), 32'($countones(exp_r[idx]) % 2));
    endtask

    task automatic model_update(input int idx, input int n, input logic iv,
                                input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (!rst_n) begin
            exp_r[idx] = 32'd0;
            exp_v[idx] = 1'b0;
        end else begin
            exp_v[idx] = iv;
            if (iv) exp_r[idx] = model_op(n, a, b, op);
        end
    endtask

    // One clock: update models from the inputs seen at the edge, then check all
    task automatic cycle();
        logic        s_rst, s_iv4, s_iv8, s_iv1;
        logic [31:0] s_a4, s_b4, s_a8, s_b8, s_a1, s_b1;
        logic [1:0]  s_op4, s_op8, s_op1;
        s_rst = rst_n;
        s_iv4 = iv4; s_a4 = 32'(a4); s_b4 = 32'(b4); s_op4 = op4;
        s_iv8 = iv8; s_a8 = 32'(a8); s_b8 = 32'(b8); s_op8 = op8;
        s_iv1 = iv1; s_a1 = 32'(a1); s_b1 = 32'(b1); s_op1 = op1;
        @(posedge clk);
        #1;
        if (s_rst !== rst_n) $fatal(1, "FAIL stimulus: rst_n changed across edge");
        model_update(0, 4, s_iv4, s_a4, s_b4, s_op4);
        model_update(1, 8, s_iv8, s_a8, s_b8, s_op8);
        model_update(2, 1, s_iv1, s_a1, s_b1, s_op1);
        chk_inst("n4", 0, 4, 32'(r4), ov4, z4, o4, p4);
        chk_inst("n8", 1, 8, 32'(r8), ov8, z8, o8, p8);
        chk_inst("n1", 2, 1, 32'(r1), ov1, z1, o1, p1);
        $display("cycle rst_n=%0b n4: iv=%0b op=%0d A=%0h B=%0h -> result=%0h valid=%0b",
                 rst_n, s_iv4, s_op4, s_a4, s_b4, r4, ov4);
    endtask

    task automatic drive4(input logic iv, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op);
        iv4 = iv; a4 = a; b4 = b; op4 = op;
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        iv1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
        drive4(1'b1, 4'hF, 4'hF, 2'd0);
        #2;

        // Reset dominates in_valid
        cycle();
        cycle();
        chk("reset_result", 32'(r4), 32'd0);
        chk("reset_valid", 32'(ov4), 32'd0);
        chk("reset_zero", 32'(z4), 32'd1);
        chk("reset_ones", 32'(o4), 32'd0);
        chk("reset_parity", 32'(p4), 32'd0);

        rst_n = 1'b1;
        // Opcode sweep
        drive4(1'b1, 4'b0010, 4'b0001, 2'd0); cycle();
        chk("sweep_and", 32'(r4), 32'd0);  chk("sweep_and_zero", 32'(z4), 32'd1);
        chk("sweep_and_valid", 32'(ov4), 32'd1);
        drive4(1'b1, 4'b0010, 4'b0001, 2'd1); cycle();
        chk("sweep_or", 32'(r4), 32'd3);
        drive4(1'b1, 4'b0010, 4'b0001, 2'd2); cycle();
        chk("sweep_xor", 32'(r4), 32'd3);  chk("sweep_xor_parity", 32'(p4), 32'd0);
        drive4(1'b1, 4'b0010, 4'b0001, 2'd3); cycle();
        chk("sweep_nor", 32'(r4), 32'd12);

        // Extremes
        drive4(1'b1, 4'hF, 4'hF, 2'd0); cycle();
        chk("ext_and", 32'(r4), 32'd15); chk("ext_and_ones", 32'(o4), 32'd1);
        chk("ext_and_parity", 32'(p4), 32'd0);
        drive4(1'b1, 4'hF, 4'hF, 2'd2); cycle();
        chk("ext_xor", 32'(r4), 32'd0); chk("ext_xor_zero", 32'(z4), 32'd1);
        drive4(1'b1, 4'hF, 4'hF, 2'd3); cycle();
        chk("ext_nor_ff", 32'(r4), 32'd0);
        drive4(1'b1, 4'h0, 4'h0, 2'd3); cycle();
        chk("ext_nor_00", 32'(r4), 32'd15); chk("ext_nor_00_ones", 32'(o4), 32'd1);

        // Hold with junk operands
        drive4(1'b1, 4'hA, 4'h6, 2'd0); cycle();
        chk("hold_load", 32'(r4), 32'd2);
        for (int i = 0; i < 3; i++) begin
            iv4 = 1'b0; a4 = 'x; b4 = 'x; op4 = 'x;
            cycle();
            chk("hold_result", 32'(r4), 32'd2);
            chk("hold_valid", 32'(ov4), 32'd0);
        end

        // Operation presented on the same edge reset asserts is discarded
        drive4(1'b1, 4'd5, 4'd2, 2'd1);
        rst_n = 1'b0;
        cycle();
        chk("midrst_result", 32'(r4), 32'd0);
        chk("midrst_valid", 32'(ov4), 32'd0);
        rst_n = 1'b1;
        iv4 = 1'b0;
        cycle();
        chk("midrst_after", 32'(r4), 32'd0);

        // Random regression on all widths
        for (int i = 0; i < 1000; i++) begin
            iv4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); op4 = 2'($urandom);
            iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
            iv1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); op1 = 2'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
